fnd_display_scheduler: RTL and testbench

Time-shares the single 4-digit FND between three display requesters: wash-cycle remaining time (src0), motor PWM duty (src1) and alarm/error code (src2). Normal sources rotate round-robin with a fixed dwell time. The alarm source preempts both and blinks. Output feeds the 14-bit data input of the FND display block, plus a blank control gating the segment font.

---
 rtl/fnd_display_scheduler.sv | 164 ++++++++++++++++
 tb/tb_fnd_display_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_display_scheduler.sv
// FND display scheduler: round-robin between wash time and PWM duty,
// with a blinking alarm source that preempts both.
module fnd_display_scheduler #(
  parameter int TICK_DIV = 100000,
  parameter int DWELL_MS = 2000,
  parameter int BLINK_MS = 500
) (
  input  logic        sysclk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_srcValid,
  input  logic [13:0] i_src0Data,
  input  logic [13:0] i_src1Data,
  input  logic [13:0] i_src2Data,
  output logic [13:0] o_fndData,
  output logic        o_fndBlank,
  output logic [1:0]  o_activeSrc,
  output logic [2:0]  o_srcGrant
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, ALARM} state_t;

  state_t        state_q, state_d;
  logic          cur_q, cur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [13:0]   data_q, data_d;
  logic          blank_q, blank_d;
  logic [1:0]    active_q, active_d;
  logic [2:0]    grant_q, grant_d;
  logic          ms_tick;
  logic [13:0]   sel;

  assign ms_tick = (tick_q == TW'(TICK_DIV - 1));
  assign tick_d  = ms_tick ? '0 : tick_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dwell_d = dwell_q;
    blink_d = blink_q;
    phase_d = phase_q;
    grant_d = '0;
    // Alarm wins over any dwell expiry or source drop in the same cycle.
    if (i_srcValid[2] && state_q != ALARM) begin
      state_d    = ALARM;
      blink_d    = '0;
      phase_d    = 1'b1;
      grant_d[2] = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, ALARM: begin
          if (state_q == ALARM && i_srcValid[2]) begin
            if (ms_tick) begin
              if (blink_q == BW'(BLINK_MS - 1)) begin
                blink_d = '0;
                phase_d = ~phase_q;
              end else begin
                blink_d = blink_q + 1'b1;
              end
            end
          end else if (i_srcValid[cur_q]) begin
            state_d = SHOW;
            dwell_d = '0;
            grant_d = cur_q ? 3'b010 : 3'b001;
          end else if (i_srcValid[~cur_q]) begin
            state_d = SHOW;
            cur_d   = ~cur_q;
            dwell_d = '0;
            grant_d = cur_q ? 3'b001 : 3'b010;
          end else begin
            state_d = IDLE;
          end
        end
        SHOW: begin
          if (!i_srcValid[cur_q]) begin
            if (i_srcValid[~cur_q]) begin
              cur_d   = ~cur_q;
              dwell_d = '0;
              grant_d = cur_q ? 3'b001 : 3'b010;
            end else begin
              state_d = IDLE;
            end
          end else if (ms_tick) begin
            if (dwell_q == DW'(DWELL_MS - 1)) begin
              dwell_d = '0;
              if (i_srcValid[~cur_q]) begin
                cur_d   = ~cur_q;
                grant_d = cur_q ? 3'b001 : 3'b010;
              end
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    active_d = 2'd3;
    blank_d  = 1'b1;
    unique case (state_d)
      SHOW: begin
        active_d = {1'b0, cur_d};
        blank_d  = 1'b0;
      end
      ALARM: begin
        active_d = 2'd2;
        blank_d  = ~phase_d;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel = '0;
    unique case (active_q)
      2'd0:    sel = i_src0Data;
      2'd1:    sel = i_src1Data;
      2'd2:    sel = i_src2Data;
      default: sel = '0;
    endcase
    data_d = (sel > 14'd9999) ? 14'd9999 : sel;
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cur_q    <= 1'b0;
      tick_q   <= '0;
      dwell_q  <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      data_q   <= '0;
      blank_q  <= 1'b1;
      active_q <= 2'd3;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tick_q   <= tick_d;
      dwell_q  <= dwell_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      data_q   <= data_d;
      blank_q  <= blank_d;
      active_q <= active_d;
      grant_q  <= grant_d;
    end
  end

  assign o_fndData   = data_q;
  assign o_fndBlank  = blank_q;
  assign o_activeSrc = active_q;
  assign o_srcGrant  = grant_q;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed bench for fnd_display_scheduler with short tick/dwell/blink
// constants (4 cycles/ms, 3 ms dwell, 2 ms blink phase).
module tb_fnd_display_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic [13:0] s0, s1, s2;
  logic [13:0] fnd_data;
  logic        fnd_blank;
  logic [1:0]  active;
  logic [2:0]  grant;

  int tests = 0;
  int fails = 0;

  fnd_display_scheduler #(
    .TICK_DIV(4),
    .DWELL_MS(3),
    .BLINK_MS(2)
  ) dut (
    .sysclk     (clk),
    .i_rst_n    (rst_n),
    .i_srcValid (valid),
    .i_src0Data (s0),
    .i_src1Data (s1),
    .i_src2Data (s2),
    .o_fndData  (fnd_data),
    .o_fndBlank (fnd_blank),
    .o_activeSrc(active),
    .o_srcGrant (grant)
  );

  always #5 clk = ~clk;

  task automatic wait_grant(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant === 3'b000 && n < bound);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 3'b000;
    s0 = 14'd0; s1 = 14'd0; s2 = 14'd0;
    repeat (3) @(negedge clk);
    tests++;
    if (active !== 2'd3 || fnd_blank !== 1'b1 || fnd_data !== 14'd0 || grant !== 3'b000) begin
      fails++;
      $display("FAIL reset_hold: act=%0d blank=%0d data=%0d grant=%b, want 3 1 0 000",
               active, fnd_blank, fnd_data, grant);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (active !== 2'd3 || fnd_blank !== 1'b1 || fnd_data !== 14'd0 || grant !== 3'b000) begin
        fails++;
        $display("FAIL idle_%0d: act=%0d blank=%0d data=%0d grant=%b, want 3 1 0 000",
                 i, active, fnd_blank, fnd_data, grant);
      end
    end
  endtask

  task automatic test_single();
    valid = 3'b001;
    s0 = 14'd1234;
    @(negedge clk);
    tests++;
    if (active !== 2'd0 || grant !== 3'b001 || fnd_blank !== 1'b0) begin
      fails++;
      $display("FAIL single_grant: act=%0d grant=%b blank=%0d, want 0 001 0",
               active, grant, fnd_blank);
    end
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd1234) begin
      fails++;
      $display("FAIL single_data: got %0d want 1234", fnd_data);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if (grant !== 3'b000 || active !== 2'd0 || fnd_data !== 14'd1234) begin
        fails++;
        $display("FAIL single_hold_%0d: grant=%b act=%0d data=%0d, want 000 0 1234",
                 i, grant, active, fnd_data);
      end
    end
  endtask

  task automatic test_rotate();
    int n;
    valid = 3'b011;
    s0 = 14'd12;
    s1 = 14'd75;
    wait_grant(20, n);
    tests++;
    if (grant !== 3'b010 || active !== 2'd1) begin
      fails++;
      $display("FAIL rotate_first: grant=%b act=%0d, want 010 1", grant, active);
    end
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd75) begin
      fails++;
      $display("FAIL rotate_data1: got %0d want 75", fnd_data);
    end
    wait_grant(30, n);
    tests++;
    if (n + 1 != 12 || grant !== 3'b001 || active !== 2'd0) begin
      fails++;
      $display("FAIL rotate_to0: cycles=%0d grant=%b act=%0d, want 12 001 0",
               n + 1, grant, active);
    end
    wait_grant(30, n);
    tests++;
    if (n != 12 || grant !== 3'b010 || active !== 2'd1) begin
      fails++;
      $display("FAIL rotate_to1: cycles=%0d grant=%b act=%0d, want 12 010 1",
               n, grant, active);
    end
  endtask

  task automatic test_drop();
    int n;
    wait_grant(30, n);
    tests++;
    if (grant !== 3'b001 || active !== 2'd0) begin
      fails++;
      $display("FAIL drop_pre: grant=%b act=%0d, want 001 0", grant, active);
    end
    repeat (3) @(negedge clk);
    valid = 3'b010;
    @(negedge clk);
    tests++;
    if (active !== 2'd1 || grant !== 3'b010) begin
      fails++;
      $display("FAIL drop_switch: act=%0d grant=%b, want 1 010", active, grant);
    end
    valid = 3'b011;
    wait_grant(30, n);
    tests++;
    if (n != 12 || grant !== 3'b001) begin
      fails++;
      $display("FAIL drop_dwell: cycles=%0d grant=%b, want 12 001", n, grant);
    end
    valid = 3'b010;
    @(negedge clk);
    tests++;
    if (active !== 2'd1 || grant !== 3'b010) begin
      fails++;
      $display("FAIL drop_switch2: act=%0d grant=%b, want 1 010", active, grant);
    end
    valid = 3'b000;
    @(negedge clk);
    tests++;
    if (active !== 2'd3 || fnd_blank !== 1'b1 || grant !== 3'b000) begin
      fails++;
      $display("FAIL drop_idle: act=%0d blank=%0d grant=%b, want 3 1 000",
               active, fnd_blank, grant);
    end
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd0) begin
      fails++;
      $display("FAIL drop_idle_data: got %0d want 0", fnd_data);
    end
  endtask

  task automatic test_alarm();
    int n;
    valid = 3'b010;
    @(negedge clk);
    tests++;
    if (active !== 2'd1 || grant !== 3'b010) begin
      fails++;
      $display("FAIL alarm_pre: act=%0d grant=%b, want 1 010", active, grant);
    end
    repeat (2) @(negedge clk);
    valid = 3'b111;
    s2 = 14'd16383;
    @(negedge clk);
    tests++;
    if (active !== 2'd2 || grant !== 3'b100 || fnd_blank !== 1'b0) begin
      fails++;
      $display("FAIL alarm_enter: act=%0d grant=%b blank=%0d, want 2 100 0",
               active, grant, fnd_blank);
    end
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd9999 || grant !== 3'b000) begin
      fails++;
      $display("FAIL alarm_sat: data=%0d grant=%b, want 9999 000", fnd_data, grant);
    end
    n = 0;
    while (fnd_blank !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (fnd_blank === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL blink_off: blank cycles=%0d want 8", n);
    end
    n = 0;
    while (fnd_blank === 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL blink_on: visible cycles=%0d want 8", n);
    end
    tests++;
    if (fnd_data !== 14'd9999 || active !== 2'd2) begin
      fails++;
      $display("FAIL blank_data: data=%0d act=%0d, want 9999 2", fnd_data, active);
    end
    s2 = 14'd10000;
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd9999) begin
      fails++;
      $display("FAIL sat_10000: got %0d want 9999", fnd_data);
    end
    s2 = 14'd9998;
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd9998) begin
      fails++;
      $display("FAIL live_9998: got %0d want 9998", fnd_data);
    end
    valid = 3'b011;
    @(negedge clk);
    tests++;
    if (active !== 2'd1 || grant !== 3'b010 || fnd_blank !== 1'b0) begin
      fails++;
      $display("FAIL alarm_exit: act=%0d grant=%b blank=%0d, want 1 010 0",
               active, grant, fnd_blank);
    end
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd75) begin
      fails++;
      $display("FAIL exit_data: got %0d want 75", fnd_data);
    end
  endtask

  task automatic test_async_reset();
    int n;
    valid = 3'b101;
    s2 = 14'd42;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fnd_blank !== 1'b1 && n < 20);
    @(negedge clk);
    tests++;
    if (active !== 2'd2 || fnd_blank !== 1'b1 || fnd_data !== 14'd42) begin
      fails++;
      $display("FAIL arst_pre: act=%0d blank=%0d data=%0d, want 2 1 42",
               active, fnd_blank, fnd_data);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (active !== 2'd3 || fnd_blank !== 1'b1 || fnd_data !== 14'd0 || grant !== 3'b000) begin
      fails++;
      $display("FAIL arst_now: act=%0d blank=%0d data=%0d grant=%b, want 3 1 0 000",
               active, fnd_blank, fnd_data, grant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid = 3'b001;
    s0 = 14'd1234;
    @(negedge clk);
    tests++;
    if (active !== 2'd0 || grant !== 3'b001) begin
      fails++;
      $display("FAIL arst_resume: act=%0d grant=%b, want 0 001", active, grant);
    end
    @(negedge clk);
    tests++;
    if (fnd_data !== 14'd1234) begin
      fails++;
      $display("FAIL arst_data: got %0d want 1234", fnd_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_drop();
    test_alarm();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
